// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-byte I2C master: START, address+R/W, one data byte, STOP.
// Optional SCL clock stretching support is enabled by defining I2C_MASTER_STRETCH_EN.
module i2c_master #(
  parameter int DIVIDER = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  inout  wire        sda,
  inout  wire        scl
);

  localparam int CW = $clog2(DIVIDER);
  localparam logic [CW-1:0] RELOAD = CW'(DIVIDER - 1);

  typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, WRITE, READ, ACK2, STOP} state_t;

  state_t        state, nxt_state;
  logic [1:0]    q, nxt_q;
  logic [2:0]    bit_cnt, nxt_bit;
  logic [CW-1:0] cnt;
  logic [7:0]    addr_byte, wr_byte, rx_byte;
  logic          rw_r, sample;
  logic          sda_low, scl_low, nxt_sda_low, nxt_scl_low;
  logic          tick, hold;

  assign sda  = sda_low ? 1'b0 : 1'bz;
  assign scl  = scl_low ? 1'b0 : 1'bz;
  assign tick = (state != IDLE) && (cnt == '0) && !hold;

  // Next slot/quarter position and the line levels that go with it.
  always_comb begin
    nxt_state = state;
    nxt_q     = q + 2'd1;
    nxt_bit   = bit_cnt;
    if (q == 2'd3) begin
      case (state)
        START: begin nxt_state = ADDR; nxt_bit = 3'd7; end
        ADDR:  if (bit_cnt == 3'd0) nxt_state = ACK1; else nxt_bit = bit_cnt - 3'd1;
        ACK1:  if (sample) nxt_state = STOP;
               else begin nxt_state = rw_r ? READ : WRITE; nxt_bit = 3'd7; end
        WRITE, READ: if (bit_cnt == 3'd0) nxt_state = ACK2; else nxt_bit = bit_cnt - 3'd1;
        ACK2:  nxt_state = STOP;
        default: nxt_state = IDLE;
      endcase
    end
    nxt_scl_low = 1'b0;
    nxt_sda_low = 1'b0;
    case (nxt_state)
      START: nxt_sda_low = nxt_q[1];
      ADDR:  begin nxt_scl_low = !nxt_q[1]; nxt_sda_low = !addr_byte[nxt_bit]; end
      WRITE: begin nxt_scl_low = !nxt_q[1]; nxt_sda_low = !wr_byte[nxt_bit]; end
      ACK1, READ, ACK2: nxt_scl_low = !nxt_q[1];
      STOP:  begin nxt_scl_low = !nxt_q[1]; nxt_sda_low = (nxt_q != 2'd3); end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q         <= 2'd0;
      bit_cnt   <= 3'd0;
      cnt       <= RELOAD;
      addr_byte <= 8'd0;
      wr_byte   <= 8'd0;
      rx_byte   <= 8'd0;
      rw_r      <= 1'b0;
      sample    <= 1'b1;
      sda_low   <= 1'b0;
      scl_low   <= 1'b0;
      rd_data   <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_error <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          addr_byte <= {addr, rw};
          wr_byte   <= wr_data;
          rw_r      <= rw;
          busy      <= 1'b1;
          ack_error <= 1'b0;
          state     <= START;
          q         <= 2'd0;
          cnt       <= RELOAD;
          sda_low   <= 1'b0;
          scl_low   <= 1'b0;
        end
      end else if (tick) begin
        cnt     <= RELOAD;
        state   <= nxt_state;
        q       <= nxt_q;
        bit_cnt <= nxt_bit;
        sda_low <= nxt_sda_low;
        scl_low <= nxt_scl_low;
        if (q == 2'd2) begin
          sample <= sda;
          if (state == READ) rx_byte <= {rx_byte[6:0], sda};
        end
        if (q == 2'd3) begin
          if (state == ACK1 && sample) ack_error <= 1'b1;
          if (state == ACK2 && !rw_r && sample) ack_error <= 1'b1;
          if (state == ACK2 && rw_r) rd_data <= rx_byte;
          if (state == STOP) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
      end else if (!hold) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

`ifdef I2C_MASTER_STRETCH_EN
  // The first two Q2 cycles are skipped because the synchroniser still shows our own low drive.
  logic [1:0] scl_sync;
  logic [1:0] rel_age;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      rel_age  <= 2'd2;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      if (tick && q == 2'd1) rel_age <= 2'd0;
      else if (rel_age != 2'd2) rel_age <= rel_age + 2'd1;
    end
  end

  assign hold = (state != IDLE) && (q == 2'd2) && (rel_age == 2'd2) && !scl_sync[1];
`else
  assign hold = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - directed self-checking bench for i2c_master with a slot-timed slave.
module tb_i2c_master;
  localparam int DIV  = 4;
  localparam int SLOT = 4 * DIV;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, rw = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] rd_data;
  logic       busy, done, ack_error;
  wire        sda, scl;

  pullup (sda);
  pullup (scl);

  logic slv_sda_low = 1'b0, slv_scl_low = 1'b0;
  assign sda = slv_sda_low ? 1'b0 : 1'bz;
  assign scl = slv_scl_low ? 1'b0 : 1'bz;

  i2c_master #(.DIVIDER(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .rw(rw), .wr_data(wr_data),
    .rd_data(rd_data), .busy(busy), .done(done), .ack_error(ack_error), .sda(sda), .scl(scl)
  );

  always #5 clk = ~clk;

  int cyc = 0, done_cnt = 0, mon_n = 0, start_ev = 0, stop_ev = 0;
  logic [31:0] mon_bits = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;
  always @(posedge scl) begin
    mon_bits <= {mon_bits[30:0], sda};
    mon_n    <= mon_n + 1;
  end
  always @(negedge sda) #1 if (scl === 1'b1) start_ev <= start_ev + 1;
  always @(posedge sda) #1 if (scl === 1'b1) stop_ev <= stop_ev + 1;

  // Slave acts 2 cycles into each slot (SCL low); slots after a stretch are shifted back.
  logic       slv_active = 1'b0, slv_ack = 1'b0, slv_read = 1'b0;
  logic [7:0] slv_resp = 8'd0;
  int         slv_t0 = 0, slv_str = 0, raw_rel, rel;

  always_comb begin
    raw_rel = cyc + 1 - slv_t0;
    rel     = (raw_rel > 9 * SLOT + 2 * DIV + slv_str) ? raw_rel - slv_str : raw_rel;
  end

  always @(posedge clk) begin
    if (!slv_active) begin
      slv_sda_low <= 1'b0;
      slv_scl_low <= 1'b0;
    end else begin
      if (rel % SLOT == 2) begin
        if (rel / SLOT == 9) slv_sda_low <= slv_ack;
        else if (rel / SLOT >= 10 && rel / SLOT <= 17 && slv_read) slv_sda_low <= !slv_resp[17 - rel / SLOT];
        else if (rel / SLOT == 18 && !slv_read) slv_sda_low <= slv_ack;
        else slv_sda_low <= 1'b0;
      end
      if (slv_str != 0 && raw_rel == 9 * SLOT + 2) slv_scl_low <= 1'b1;
      if (slv_str != 0 && raw_rel == 9 * SLOT + 2 * DIV + slv_str) slv_scl_low <= 1'b0;
    end
  end

  int nchk = 0, npass = 0, nfail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [6:0] a, input logic r, input logic [7:0] d,
                        input logic ack, input logic [7:0] resp, output int t0);
    addr = a; rw = r; wr_data = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    slv_t0 = cyc; slv_ack = ack; slv_read = r; slv_resp = resp; slv_active = 1'b1;
  endtask

  task automatic wait_done(input int t0, input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  initial begin
    int t0, t1, lat, b0, s0, p0, d0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ack_error", 32'(ack_error), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_scl", 32'(scl), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write 0xA5 to 0x2A
    b0 = mon_n; s0 = start_ev; p0 = stop_ev;
    launch(7'h2A, 1'b0, 8'hA5, 1'b1, 8'h00, t0);
    check("wr_busy", 32'(busy), 32'd1);
    wait_done(t0, 400, lat);
    check("wr_latency", 32'(lat), 32'd320);
    check("wr_busy_at_done", 32'(busy), 32'd0);
    check("wr_ack_error", 32'(ack_error), 32'd0);
    check("wr_rd_data", 32'(rd_data), 32'd0);
    check("wr_nbits", 32'(mon_n - b0), 32'd19);
    check("wr_bits", 32'(mon_bits[18:0]), 32'(19'b0101010_0_0_1010_0101_0_0));
    check("wr_start_ev", 32'(start_ev - s0), 32'd1);
    check("wr_stop_ev", 32'(stop_ev - p0), 32'd1);
    repeat (4) @(posedge clk);
    #1;

    // Read from 0x2A, slave returns 0xCC
    b0 = mon_n; p0 = stop_ev;
    launch(7'h2A, 1'b1, 8'h00, 1'b1, 8'hCC, t0);
    wait_done(t0, 400, lat);
    check("rd_latency", 32'(lat), 32'd320);
    check("rd_data", 32'(rd_data), 32'hCC);
    check("rd_ack_error", 32'(ack_error), 32'd0);
    check("rd_bits", 32'(mon_bits[18:0]), 32'(19'b0101010_1_0_1100_1100_1_0));
    check("rd_stop_ev", 32'(stop_ev - p0), 32'd1);
    repeat (4) @(posedge clk);
    #1;

    // Address 0x11, nobody answers
    b0 = mon_n; p0 = stop_ev;
    launch(7'h11, 1'b0, 8'h77, 1'b0, 8'h00, t0);
    wait_done(t0, 400, lat);
    check("nack_latency", 32'(lat), 32'd176);
    check("nack_ack_error", 32'(ack_error), 32'd1);
    check("nack_nbits", 32'(mon_n - b0), 32'd10);
    check("nack_bits", 32'(mon_bits[9:0]), 32'(10'b0010001_0_1_0));
    check("nack_stop_ev", 32'(stop_ev - p0), 32'd1);
    check("nack_rd_data_kept", 32'(rd_data), 32'hCC);
    repeat (4) @(posedge clk);
    #1;
    check("nack_sda_idle", 32'(sda), 32'd1);
    check("nack_scl_idle", 32'(scl), 32'd1);
    check("nack_ack_error_held", 32'(ack_error), 32'd1);

    // start pulsed mid-transfer is ignored; start right after done is accepted
    b0 = mon_n; d0 = done_cnt;
    launch(7'h2A, 1'b0, 8'h3C, 1'b1, 8'h00, t0);
    repeat (49) @(posedge clk);
    #1;
    addr = 7'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    wait_done(t0, 400, lat);
    check("ign_latency", 32'(lat), 32'd320);
    check("ign_bits", 32'(mon_bits[18:0]), 32'(19'b0101010_0_0_0011_1100_0_0));
    launch(7'h2A, 1'b0, 8'h96, 1'b1, 8'h00, t1);
    check("b2b_accept_cycle", 32'(t1 - t0), 32'd321);
    check("b2b_busy", 32'(busy), 32'd1);
    check("ign_single_done", 32'(done_cnt - d0), 32'd1);
    wait_done(t1, 400, lat);
    check("b2b_latency", 32'(lat), 32'd320);
    check("b2b_ack_error", 32'(ack_error), 32'd0);
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of the data byte
    launch(7'h2A, 1'b0, 8'hFF, 1'b1, 8'h00, t0);
    repeat (200) @(posedge clk);
    #1;
    rst_n = 1'b0; slv_active = 1'b0;
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_sda", 32'(sda), 32'd1);
    check("mid_rst_scl", 32'(scl), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("mid_rst_idle_busy", 32'(busy), 32'd0);
    b0 = mon_n;
    launch(7'h2A, 1'b0, 8'h5A, 1'b1, 8'h00, t0);
    wait_done(t0, 400, lat);
    check("post_rst_latency", 32'(lat), 32'd320);
    check("post_rst_ack_error", 32'(ack_error), 32'd0);
    check("post_rst_bits", 32'(mon_bits[18:0]), 32'(19'b0101010_0_0_0101_1010_0_0));
    repeat (4) @(posedge clk);
    #1;

`ifdef I2C_MASTER_STRETCH_EN
    // Slave stretches SCL 37 cycles in ACK1
    slv_str = 37;
    launch(7'h2A, 1'b0, 8'hA5, 1'b1, 8'h00, t0);
    wait_done(t0, 500, lat);
    check("str_latency_window", 32'(lat >= 356 && lat <= 358), 32'd1);
    check("str_bits", 32'(mon_bits[18:0]), 32'(19'b0101010_0_0_1010_0101_0_0));
    check("str_ack_error", 32'(ack_error), 32'd0);
    slv_str = 0;
    repeat (4) @(posedge clk);
    #1;
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
